// File: rtl/cajero_pkg.sv
// Shared types and defaults for the cajero_automatico_param ATM controller.
// Optional feature macro used by the family: CAJERO_TIMEOUT_EN.
package cajero_pkg;

  localparam int DEF_PIN_DIGITS = 4;
  localparam int DEF_DIGIT_W    = 4;
  localparam int DEF_MONTO_W    = 32;
  localparam int DEF_BAL_W      = 64;
  localparam int DEF_MAX_TRIES  = 3;

  localparam logic TIPO_DEPOSITO = 1'b0;
  localparam logic TIPO_RETIRO   = 1'b1;

  typedef enum logic [2:0] {
    IDLE          = 3'd0,
    LEER_PIN      = 3'd1,
    VERIFICAR_PIN = 3'd2,
    ESPERA_MONTO  = 3'd3,
    PROCESAR      = 3'd4,
    BLOQUEADO     = 3'd5
  } state_t;

endpackage

// File: rtl/cajero_automatico_param_if.sv
// Keypad / transaction / result bundle for cajero_automatico_param.
// With CAJERO_TIMEOUT_EN defined the bundle also carries the TIMEOUT pulse.
interface cajero_automatico_param_if
  import cajero_pkg::*;
#(
  parameter int PIN_DIGITS = DEF_PIN_DIGITS,
  parameter int DIGIT_W    = DEF_DIGIT_W,
  parameter int MONTO_W    = DEF_MONTO_W,
  parameter int BAL_W      = DEF_BAL_W
);

  logic                          TARJETA_RECIBIDA;
  logic                          TIPO_TRANS;
  logic                          MONTO_STB;
  logic [MONTO_W-1:0]            MONTO;
  logic                          DIGITO_STB;
  logic [DIGIT_W-1:0]            DIGITO;
  logic [PIN_DIGITS*DIGIT_W-1:0] PIN;
  logic [BAL_W-1:0]              BALANCE_INICIAL;
  logic [BAL_W-1:0]              BALANCE_FINAL;
  logic                          BALANCE_ACTUALIZADO;
  logic                          ENTREGAR_DINERO;
  logic                          PIN_INCORRECTO;
  logic                          ADVERTENCIA;
  logic                          BLOQUEO;
  logic                          FONDOS_INSUFICIENTES;
  logic                          DESBORDE;
`ifdef CAJERO_TIMEOUT_EN
  logic                          TIMEOUT;
`endif

  modport master (
    output TARJETA_RECIBIDA, TIPO_TRANS, MONTO_STB, MONTO, DIGITO_STB, DIGITO,
           PIN, BALANCE_INICIAL,
    input  BALANCE_FINAL, BALANCE_ACTUALIZADO, ENTREGAR_DINERO, PIN_INCORRECTO,
           ADVERTENCIA, BLOQUEO, FONDOS_INSUFICIENTES, DESBORDE
`ifdef CAJERO_TIMEOUT_EN
    , input TIMEOUT
`endif
  );

  modport slave (
    input  TARJETA_RECIBIDA, TIPO_TRANS, MONTO_STB, MONTO, DIGITO_STB, DIGITO,
           PIN, BALANCE_INICIAL,
    output BALANCE_FINAL, BALANCE_ACTUALIZADO, ENTREGAR_DINERO, PIN_INCORRECTO,
           ADVERTENCIA, BLOQUEO, FONDOS_INSUFICIENTES, DESBORDE
`ifdef CAJERO_TIMEOUT_EN
    , output TIMEOUT
`endif
  );

endinterface

// File: rtl/cajero_automatico_param_pin_capture.sv
// PIN digit capture: shift register (newest digit in the LSBs) plus digit counter.
module pin_capture #(
  parameter int PIN_DIGITS = 4,
  parameter int DIGIT_W    = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          clr,
  input  logic                          shift_en,
  input  logic [DIGIT_W-1:0]            digit,
  output logic                          digits_full,
  output logic [PIN_DIGITS*DIGIT_W-1:0] value
);

  localparam int VW = PIN_DIGITS * DIGIT_W;
  localparam int CW = $clog2(PIN_DIGITS + 1);

  logic [VW-1:0] cap_q, cap_d;
  logic [CW-1:0] cnt_q, cnt_d;

  // clear wins over shift so a rejected entry never leaks a stray digit
  always_comb begin
    cap_d = cap_q;
    cnt_d = cnt_q;
    if (clr) begin
      cap_d = '0;
      cnt_d = '0;
    end else if (shift_en) begin
      cap_d = {cap_q[VW-DIGIT_W-1:0], digit};
      cnt_d = cnt_q + 1'b1;
    end
  end

  // capture and counter registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cap_q <= '0;
      cnt_q <= '0;
    end else begin
      cap_q <= cap_d;
      cnt_q <= cnt_d;
    end
  end

  // high when the next accepted strobe completes the PIN
  assign digits_full = (cnt_q == CW'(PIN_DIGITS - 1));
  assign value       = cap_q;

endmodule

// File: rtl/cajero_automatico_param.sv
// ATM transaction controller: PIN entry with retry limit / lock-out, then one
// deposit or withdrawal against the supplied balance.
// Optional: CAJERO_TIMEOUT_EN adds an inactivity down-counter and TIMEOUT pulse.
//
// state         | meaning
// IDLE          | no session, waiting for a card
// LEER_PIN      | collecting keypad digits
// VERIFICAR_PIN | one cycle: compare captured digits with card PIN
// ESPERA_MONTO  | PIN good, waiting for the amount strobe
// PROCESAR      | one cycle: apply deposit/withdrawal, emit result pulse
// BLOQUEADO     | card locked, only reset leaves
module cajero_automatico_param
  import cajero_pkg::*;
#(
  parameter int PIN_DIGITS = DEF_PIN_DIGITS,
  parameter int DIGIT_W    = DEF_DIGIT_W,
  parameter int MONTO_W    = DEF_MONTO_W,
  parameter int BAL_W      = DEF_BAL_W,
  parameter int MAX_TRIES  = DEF_MAX_TRIES
`ifdef CAJERO_TIMEOUT_EN
  , parameter int TIMEOUT_CYC = 1000
`endif
) (
  input logic                     clk,
  input logic                     rst,
  cajero_automatico_param_if.slave bus
);

  localparam int IW = $clog2(MAX_TRIES + 1);
  localparam logic [IW-1:0] TRIES_LOCK = IW'(MAX_TRIES);
  localparam logic [IW-1:0] TRIES_WARN = IW'(MAX_TRIES - 1);

  state_t state_q, state_d;
  logic [IW-1:0]      intentos_q, intentos_d, intentos_inc;
  logic               pin_inc_q, pin_inc_d;
  logic               adv_q, adv_d;
  logic               bloq_q, bloq_d;
  logic [BAL_W-1:0]   balance_q, balance_d;
  logic [MONTO_W-1:0] monto_q, monto_d;
  logic               tipo_q, tipo_d;
  logic               bal_act_q, bal_act_d;
  logic               entregar_q, entregar_d;
  logic               fondos_q, fondos_d;
  logic               desborde_q, desborde_d;

  logic                          cap_clr, cap_shift, cap_full;
  logic [PIN_DIGITS*DIGIT_W-1:0] cap_value;
  logic                          pin_ok;
  logic [BAL_W:0]                sum;
  logic [BAL_W-1:0]              monto_bal;
  logic                          keep_sess;

`ifdef CAJERO_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYC + 1);
  logic [TW-1:0] tmr_q, tmr_d;
  logic          timeout_q, timeout_d;
  logic          keep_q, keep_d;
  assign keep_sess = keep_q;
`else
  assign keep_sess = 1'b0;
`endif

  pin_capture #(
    .PIN_DIGITS (PIN_DIGITS),
    .DIGIT_W    (DIGIT_W)
  ) u_pin_capture (
    .clk         (clk),
    .rst         (rst),
    .clr         (cap_clr),
    .shift_en    (cap_shift),
    .digit       (bus.DIGITO),
    .digits_full (cap_full),
    .value       (cap_value)
  );

  assign pin_ok       = (cap_value == bus.PIN);
  assign intentos_inc = intentos_q + 1'b1;
  assign monto_bal    = BAL_W'(monto_q);
  assign sum          = {1'b0, bus.BALANCE_INICIAL} + {1'b0, monto_bal};

  // next-state, session flags and result pulses
  always_comb begin
    state_d    = state_q;
    intentos_d = intentos_q;
    pin_inc_d  = pin_inc_q;
    adv_d      = adv_q;
    bloq_d     = bloq_q;
    balance_d  = balance_q;
    monto_d    = monto_q;
    tipo_d     = tipo_q;
    bal_act_d  = 1'b0;
    entregar_d = 1'b0;
    fondos_d   = 1'b0;
    desborde_d = 1'b0;
    cap_clr    = 1'b0;
    cap_shift  = 1'b0;

    case (state_q)
      IDLE: begin
        cap_clr = 1'b1;
        if (bus.TARJETA_RECIBIDA) begin
          state_d = LEER_PIN;
          if (!keep_sess) begin
            intentos_d = '0;
            pin_inc_d  = 1'b0;
            adv_d      = 1'b0;
          end
        end
      end
      LEER_PIN: begin
        if (!bus.TARJETA_RECIBIDA) begin
          state_d = IDLE;
        end else if (bus.DIGITO_STB) begin
          cap_shift = 1'b1;
          if (cap_full) state_d = VERIFICAR_PIN;
        end
      end
      VERIFICAR_PIN: begin
        if (!bus.TARJETA_RECIBIDA) begin
          state_d = IDLE;
        end else if (pin_ok) begin
          pin_inc_d = 1'b0;
          adv_d     = 1'b0;
          state_d   = ESPERA_MONTO;
        end else begin
          intentos_d = intentos_inc;
          pin_inc_d  = 1'b1;
          cap_clr    = 1'b1;
          if (intentos_inc == TRIES_WARN) adv_d = 1'b1;
          if (intentos_inc == TRIES_LOCK) begin
            bloq_d  = 1'b1;
            state_d = BLOQUEADO;
          end else begin
            state_d = LEER_PIN;
          end
        end
      end
      ESPERA_MONTO: begin
        if (!bus.TARJETA_RECIBIDA) begin
          state_d = IDLE;
        end else if (bus.MONTO_STB) begin
          monto_d = bus.MONTO;
          tipo_d  = bus.TIPO_TRANS;
          state_d = PROCESAR;
        end
      end
      PROCESAR: begin
        state_d = IDLE;
        if (tipo_q == TIPO_RETIRO) begin
          if (monto_bal <= bus.BALANCE_INICIAL) begin
            balance_d  = bus.BALANCE_INICIAL - monto_bal;
            bal_act_d  = 1'b1;
            entregar_d = 1'b1;
          end else begin
            fondos_d = 1'b1;
          end
        end else if (tipo_q == TIPO_DEPOSITO) begin
          if (sum[BAL_W]) begin
            desborde_d = 1'b1;
          end else begin
            balance_d = sum[BAL_W-1:0];
            bal_act_d = 1'b1;
          end
        end
      end
      BLOQUEADO: begin
        bloq_d = 1'b1;
      end
      default: state_d = IDLE;
    endcase

`ifdef CAJERO_TIMEOUT_EN
    // inactivity timer; a timeout with the card still in keeps the try count
    tmr_d     = tmr_q;
    timeout_d = 1'b0;
    keep_d    = keep_q;
    if (state_q == IDLE) keep_d = 1'b0;
    if ((state_q == LEER_PIN || state_q == ESPERA_MONTO) &&
        bus.TARJETA_RECIBIDA && (tmr_q == '0)) begin
      state_d   = IDLE;
      cap_shift = 1'b0;
      timeout_d = 1'b1;
      keep_d    = 1'b1;
    end else if ((state_d == LEER_PIN || state_d == ESPERA_MONTO) &&
                 ((state_d != state_q) || cap_shift)) begin
      tmr_d = TW'(TIMEOUT_CYC);
    end else if ((state_q == LEER_PIN || state_q == ESPERA_MONTO) && (tmr_q != '0)) begin
      tmr_d = tmr_q - 1'b1;
    end
`endif
  end

  // state and output registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      intentos_q <= '0;
      pin_inc_q  <= 1'b0;
      adv_q      <= 1'b0;
      bloq_q     <= 1'b0;
      balance_q  <= '0;
      monto_q    <= '0;
      tipo_q     <= 1'b0;
      bal_act_q  <= 1'b0;
      entregar_q <= 1'b0;
      fondos_q   <= 1'b0;
      desborde_q <= 1'b0;
`ifdef CAJERO_TIMEOUT_EN
      tmr_q      <= '0;
      timeout_q  <= 1'b0;
      keep_q     <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      intentos_q <= intentos_d;
      pin_inc_q  <= pin_inc_d;
      adv_q      <= adv_d;
      bloq_q     <= bloq_d;
      balance_q  <= balance_d;
      monto_q    <= monto_d;
      tipo_q     <= tipo_d;
      bal_act_q  <= bal_act_d;
      entregar_q <= entregar_d;
      fondos_q   <= fondos_d;
      desborde_q <= desborde_d;
`ifdef CAJERO_TIMEOUT_EN
      tmr_q      <= tmr_d;
      timeout_q  <= timeout_d;
      keep_q     <= keep_d;
`endif
    end
  end

  assign bus.BALANCE_FINAL        = balance_q;
  assign bus.BALANCE_ACTUALIZADO  = bal_act_q;
  assign bus.ENTREGAR_DINERO      = entregar_q;
  assign bus.PIN_INCORRECTO       = pin_inc_q;
  assign bus.ADVERTENCIA          = adv_q;
  assign bus.BLOQUEO              = bloq_q;
  assign bus.FONDOS_INSUFICIENTES = fondos_q;
  assign bus.DESBORDE             = desborde_q;
`ifdef CAJERO_TIMEOUT_EN
  assign bus.TIMEOUT              = timeout_q;
`endif

endmodule

// File: doc/cajero_automatico_param.md
Name: cajero_automatico_param

Overview:
Parametrised next-generation ATM transaction controller for the Tarea3 cajero family.
- Captures a PIN_DIGITS-digit PIN from the keypad strobe and compares it with the card PIN.
- Enforces a configurable retry limit with warning and lock-out.
- Executes one deposit or withdrawal against a BAL_W-bit balance, including deposit-overflow detection and card-removal abort.

Parameters:
PIN_DIGITS, 4, number of PIN digits (>=2)
DIGIT_W, 4, bits per keypad digit
MONTO_W, 32, transaction amount width (MONTO_W <= BAL_W)
BAL_W, 64, account balance width
MAX_TRIES, 3, wrong-PIN entries that trigger BLOQUEO (>=2)

Ports:
clk  in  1  system clock, rising edge
rst  in  1  asynchronous, active-high reset
TARJETA_RECIBIDA  in  1  card present (level)
TIPO_TRANS  in  1  0 = deposit, 1 = withdrawal; sampled with MONTO_STB
MONTO_STB  in  1  one-cycle strobe, MONTO valid
MONTO  in  MONTO_W  transaction amount
DIGITO_STB  in  1  one-cycle strobe, DIGITO valid
DIGITO  in  DIGIT_W  keyed digit
PIN  in  PIN_DIGITS*DIGIT_W  card PIN; first digit in MSBs
BALANCE_INICIAL  in  BAL_W  balance; valid from the last PIN digit until the transaction ends
BALANCE_FINAL  out  BAL_W  registered updated balance
BALANCE_ACTUALIZADO  out  1  one-cycle pulse, balance updated
ENTREGAR_DINERO  out  1  one-cycle pulse, dispense MONTO
PIN_INCORRECTO  out  1  level, last PIN entry was wrong
ADVERTENCIA  out  1  level, one try remaining
BLOQUEO  out  1  level, card locked
FONDOS_INSUFICIENTES  out  1  one-cycle pulse, withdrawal rejected
DESBORDE  out  1  one-cycle pulse, deposit rejected on overflow

Behaviour:
- Reset (async): state IDLE; every output 0; BALANCE_FINAL 0; intentos 0; digit counter 0.
- States: IDLE, LEER_PIN, VERIFICAR_PIN, ESPERA_MONTO, PROCESAR, BLOQUEADO.
- IDLE -> LEER_PIN when TARJETA_RECIBIDA=1. Entering LEER_PIN from IDLE clears intentos, PIN_INCORRECTO and ADVERTENCIA.
- LEER_PIN:
  - Each DIGITO_STB shifts DIGITO into the capture register LSB side and increments the counter.
  - On the PIN_DIGITS-th strobe, go to VERIFICAR_PIN.
- VERIFICAR_PIN (1 cycle), compares capture register with PIN:
  - Match: PIN_INCORRECTO<=0, ADVERTENCIA<=0, go to ESPERA_MONTO.
  - Mismatch: intentos+1, PIN_INCORRECTO<=1, counter and capture cleared.
    - ADVERTENCIA<=1 when the new intentos == MAX_TRIES-1.
    - When the new intentos == MAX_TRIES: BLOQUEO<=1 and go to BLOQUEADO; otherwise return to LEER_PIN.
- ESPERA_MONTO: on MONTO_STB, register MONTO and TIPO_TRANS, go to PROCESAR.
- PROCESAR (1 cycle), then IDLE:
  - Deposit: sum is BAL_W+1 bits. If carry=1, DESBORDE pulse and no update; else BALANCE_FINAL<=sum and BALANCE_ACTUALIZADO pulse.
  - Withdrawal: if MONTO (zero-extended) <= BALANCE_INICIAL, BALANCE_FINAL<=difference and pulse BALANCE_ACTUALIZADO and ENTREGAR_DINERO together; else FONDOS_INSUFICIENTES pulse and BALANCE_FINAL unchanged.
- Latency:
  - Last DIGITO_STB to PIN_INCORRECTO / ADVERTENCIA / BLOQUEO: 2 cycles.
  - MONTO_STB to result pulse: 2 cycles.
- BLOQUEADO: absorbing; BLOQUEO held at 1; all strobes ignored. Only rst exits.
- Card removal: TARJETA_RECIBIDA=0 in LEER_PIN, VERIFICAR_PIN or ESPERA_MONTO aborts to IDLE next cycle with no pulses; BALANCE_FINAL is held.
- Strobe priority:
  - DIGITO_STB is ignored outside LEER_PIN.
  - MONTO_STB is ignored outside ESPERA_MONTO.
  - Both strobes in the same cycle: only the one valid for the current state acts.
- PROCESAR always returns to IDLE. A new session needs TARJETA_RECIBIDA high in IDLE; a card held continuously starts a new session.
- All outputs are registered.

Optional Feature:
CAJERO_TIMEOUT_EN
- Defined: adds parameter TIMEOUT_CYC (default 1000) and a down-counter.
  - Reloaded on entry to LEER_PIN or ESPERA_MONTO and on every accepted strobe.
  - Reaching 0 in either state forces IDLE and pulses output TIMEOUT for one cycle.
  - intentos is preserved only if the card stays inserted.
- Undefined: no counter and no TIMEOUT port; the controller waits indefinitely.

Decomposition:
- Package cajero_pkg: state encoding constants, default widths, and the TIPO_DEPOSITO/TIPO_RETIRO constants.
- Sub-module pin_capture (parametrised PIN_DIGITS, DIGIT_W):
  - Shift register plus digit counter.
  - Outputs: digits_full, the captured value, and a clear input.

Test Plan:
- PIN 16'h1234, digits 1,2,3,4, deposit MONTO=500, BALANCE_INICIAL=1000 -> BALANCE_FINAL=1500, BALANCE_ACTUALIZADO 1 cycle, ENTREGAR_DINERO 0.
- Correct PIN, withdrawal MONTO=2000, BALANCE_INICIAL=1000 -> FONDOS_INSUFICIENTES pulse, BALANCE_FINAL unchanged.
- Withdrawal MONTO=1000, BALANCE_INICIAL=1000 -> BALANCE_FINAL=0, ENTREGAR_DINERO and BALANCE_ACTUALIZADO pulse together.
- Three wrong PINs (MAX_TRIES=3): 1st -> PIN_INCORRECTO; 2nd -> ADVERTENCIA; 3rd -> BLOQUEO.
  - BLOQUEO stays set and further DIGITO_STB is ignored until rst.
- Deposit MONTO=1 with BALANCE_INICIAL=all-ones -> DESBORDE pulse, no BALANCE_ACTUALIZADO.
- Card removed after 2 digits, then reinserted -> IDLE then fresh LEER_PIN; 4 correct digits accepted.
- Async rst mid-PROCESAR -> all outputs 0 immediately.
- PIN_DIGITS=6 variant: 24-bit PIN accepted.
